// File: rtl/mux_scan_nx1.sv
// mux_scan_nx1: N_CH x DATA_W channel mux with a registered valid/ready output, host-loaded manual select
// and a round-robin auto scan with DWELL samples per channel. Define MUX_CH_MASK_EN to add ch_mask (auto-scan channel skip).
module mux_scan_nx1 #(
    parameter int DATA_W = 1,
    parameter int N_CH   = 8,
    parameter int SEL_W  = 3,
    parameter int DWELL  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic                     en,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel_in,
    input  logic                     sel_load,
`ifdef MUX_CH_MASK_EN
    input  logic [N_CH-1:0]          ch_mask,
`endif
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     scan_done,
    output logic                     sel_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_reg;
    logic [SEL_W-1:0]   sel_reg;
    logic [SEL_W-1:0]   ptr_reg;
    logic [7:0]         dwell_cnt_reg;
    logic               mode_reg;

    logic [DATA_W-1:0]  ch_data [N_CH];
    logic [DATA_W-1:0]  cap_data;
    logic [SEL_W-1:0]   cur_idx;
    logic [SEL_W-1:0]   nxt_idx;
    logic [SEL_W-1:0]   cap_idx;
    logic               cur_ok;
    logic               wrap;
    logic               mode_chg;
    logic               cap_go;
    logic               cap_in_range;
    logic               dwell_last;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            assign ch_data[gi] = in_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

`ifdef MUX_CH_MASK_EN
    // Doubling the mask turns the circular search into a plain shift plus a priority pick.
    logic [2*N_CH-1:0]  mask2;
    logic [N_CH-1:0]    rot_cur;
    logic [N_CH-1:0]    rot_nxt;
    logic [SEL_W:0]     cur_off;
    logic [SEL_W:0]     cur_sum;
    logic [SEL_W:0]     nxt_off;
    logic [SEL_W:0]     nxt_sum;

    assign mask2   = {ch_mask, ch_mask};
    assign rot_cur = N_CH'(mask2 >> ptr_reg);
    assign rot_nxt = N_CH'(mask2 >> ({1'b0, cur_idx} + (SEL_W+1)'(1)));

    // Channel to sample now: first enabled index at or after ptr.
    always_comb begin
        cur_off = '0;
        cur_ok  = 1'b0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (rot_cur[k]) begin
                cur_off = (SEL_W+1)'(k);
                cur_ok  = 1'b1;
            end
        end
        cur_sum = {1'b0, ptr_reg} + cur_off;
        if (cur_sum >= (SEL_W+1)'(N_CH)) begin
            cur_sum = cur_sum - (SEL_W+1)'(N_CH);
        end
        cur_idx = cur_sum[SEL_W-1:0];
    end

    // Next enabled index strictly after the current one; crossing N_CH-1 is the scan wrap.
    always_comb begin
        nxt_off = (SEL_W+1)'(N_CH);
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (rot_nxt[k]) begin
                nxt_off = (SEL_W+1)'(k + 1);
            end
        end
        nxt_sum = {1'b0, cur_idx} + nxt_off;
        wrap    = 1'b0;
        if (nxt_sum >= (SEL_W+1)'(N_CH)) begin
            nxt_sum = nxt_sum - (SEL_W+1)'(N_CH);
            wrap    = 1'b1;
        end
        nxt_idx = nxt_sum[SEL_W-1:0];
    end
`else
    assign cur_idx = ptr_reg;
    assign cur_ok  = 1'b1;
    assign wrap    = (ptr_reg == SEL_W'(N_CH - 1));
    assign nxt_idx = wrap ? '0 : ptr_reg + SEL_W'(1);
`endif

    assign mode_chg     = (mode != mode_reg);
    assign cap_idx      = mode ? cur_idx : sel_reg;
    assign cap_in_range = ({1'b0, cap_idx} < (SEL_W+1)'(N_CH));
    assign dwell_last   = (dwell_cnt_reg == 8'(DWELL - 1));
    assign cap_go       = (state_reg == RUN) && en && !mode_chg
                          && (!out_valid || out_ready) && (!mode || cur_ok);

    always_comb begin
        cap_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cap_idx == SEL_W'(i)) begin
                cap_data = ch_data[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            sel_reg       <= '0;
            ptr_reg       <= '0;
            dwell_cnt_reg <= '0;
            mode_reg      <= 1'b0;
            out_data      <= '0;
            out_sel       <= '0;
            out_valid     <= 1'b0;
            scan_done     <= 1'b0;
            sel_err       <= 1'b0;
        end else begin
            mode_reg  <= mode;
            scan_done <= 1'b0;

            if (sel_load) begin
                sel_reg <= sel_in;
            end

            case (state_reg)
                IDLE:    if (en)  state_reg <= RUN;
                RUN:     if (!en) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase

            // A mode switch restarts the scan and spends this edge without capturing.
            if (mode_chg) begin
                ptr_reg       <= '0;
                dwell_cnt_reg <= '0;
            end else if (cap_go && mode) begin
                if (dwell_last) begin
                    dwell_cnt_reg <= '0;
                    ptr_reg       <= nxt_idx;
                    scan_done     <= wrap;
                end else begin
                    dwell_cnt_reg <= dwell_cnt_reg + 8'd1;
                    ptr_reg       <= cur_idx;
                end
            end

            if (cap_go) begin
                out_valid <= 1'b1;
                out_data  <= cap_in_range ? cap_data : '0;
                out_sel   <= cap_idx;
                sel_err   <= !cap_in_range;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_nx1.sv
// tb_mux_scan_nx1: scoreboard bench for mux_scan_nx1 using three parameterisations (8ch/dwell2, 6ch/dwell1, 8ch/dwell1).
module tb_mux_scan_nx1;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en;
    logic       mode;
    logic       sel_load;
    logic       out_ready;
    logic [2:0] sel_in;
    logic [7:0] pat;
    logic [1:0] act;
    logic       en_a, en_b, en_c;
`ifdef MUX_CH_MASK_EN
    logic [7:0] mask;
`endif

    logic       v_a, d_a, dn_a, er_a;
    logic [2:0] s_a;
    logic       v_b, d_b, dn_b, er_b;
    logic [2:0] s_b;
    logic       v_c, d_c, dn_c, er_c;
    logic [2:0] s_c;

    logic       cv, cd, cdn, cer;
    logic [2:0] cs;

    assign en_a = en && (act == 2'd0);
    assign en_b = en && (act == 2'd1);
    assign en_c = en && (act == 2'd2);

    mux_scan_nx1 #(.DATA_W(1), .N_CH(8), .SEL_W(3), .DWELL(2)) u_a (
        .clk(clk), .rst(rst), .in_data(pat), .en(en_a), .mode(mode),
        .sel_in(sel_in), .sel_load(sel_load),
`ifdef MUX_CH_MASK_EN
        .ch_mask(8'hFF),
`endif
        .out_data(d_a), .out_sel(s_a), .out_valid(v_a), .out_ready(out_ready),
        .scan_done(dn_a), .sel_err(er_a)
    );

    mux_scan_nx1 #(.DATA_W(1), .N_CH(6), .SEL_W(3), .DWELL(1)) u_b (
        .clk(clk), .rst(rst), .in_data(pat[5:0]), .en(en_b), .mode(mode),
        .sel_in(sel_in), .sel_load(sel_load),
`ifdef MUX_CH_MASK_EN
        .ch_mask(6'h3F),
`endif
        .out_data(d_b), .out_sel(s_b), .out_valid(v_b), .out_ready(out_ready),
        .scan_done(dn_b), .sel_err(er_b)
    );

    mux_scan_nx1 #(.DATA_W(1), .N_CH(8), .SEL_W(3), .DWELL(1)) u_c (
        .clk(clk), .rst(rst), .in_data(pat), .en(en_c), .mode(mode),
        .sel_in(sel_in), .sel_load(sel_load),
`ifdef MUX_CH_MASK_EN
        .ch_mask(mask),
`endif
        .out_data(d_c), .out_sel(s_c), .out_valid(v_c), .out_ready(out_ready),
        .scan_done(dn_c), .sel_err(er_c)
    );

    always_comb begin
        case (act)
            2'd0:    {cv, cd, cs, cdn, cer} = {v_a, d_a, s_a, dn_a, er_a};
            2'd1:    {cv, cd, cs, cdn, cer} = {v_b, d_b, s_b, dn_b, er_b};
            default: {cv, cd, cs, cdn, cer} = {v_c, d_c, s_c, dn_c, er_c};
        endcase
    end

    // Expected item packing: {data, sel[2:0], sel_err, scan_done}
    logic [5:0] exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    string      phase = "init";

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s/%s: observed=%h expected=%h", phase, tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // The displayed item is taken at the coming edge when valid and ready are both high.
    task automatic mon();
        logic [5:0] e;
        if (cv && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", {7'b0, cv}, 8'h00);
            end else begin
                e = exp_q.pop_front();
                $display("txn %s: sel=%0d data=%0d err=%0d done=%0d (exp sel=%0d data=%0d err=%0d done=%0d)",
                         phase, cs, cd, cer, cdn, e[4:2], e[5], e[1], e[0]);
                chk("item", {2'b0, cd, cs, cer, cdn}, {2'b0, e});
            end
        end
    endtask

    task automatic drain(input int stall_at);
        int         guard;
        bit         stalled;
        logic [4:0] hold;
        guard   = 0;
        stalled = 1'b0;
        while (exp_q.size() > 0 && guard < 300) begin
            tick();
            guard++;
            if (!stalled && exp_q.size() == stall_at) begin
                stalled   = 1'b1;
                out_ready = 1'b0;
                hold      = {1'b1, exp_q[0][5], exp_q[0][4:2]};
                repeat (5) begin
                    tick();
                    chk("stall_hold", {3'b0, cv, cd, cs}, {3'b0, hold});
                end
                out_ready = 1'b1;
            end
            mon();
        end
        chk("drain_left", 8'(exp_q.size()), 8'd0);
        exp_q.delete();
        en = 1'b0;
        repeat (3) begin
            tick();
            mon();
        end
        chk("valid_low_after_drain", {7'b0, cv}, 8'h00);
    endtask

    task automatic run_manual(input string tag, input logic [1:0] dut, input int n_ch,
                              input logic [23:0] sels, input int n);
        logic [2:0] s;
        logic       er;
        phase = tag;
        act   = dut;
        mode  = 1'b0;
        tick();
        en = 1'b1;
        for (int i = 0; i < n; i++) begin
            s  = sels[3*i +: 3];
            er = (int'(s) >= n_ch);
            exp_q.push_back({er ? 1'b0 : pat[s], s, er, 1'b0});
            sel_in   = s;
            sel_load = 1'b1;
            tick();
            mon();
        end
        sel_load = 1'b0;
        drain(-1);
    endtask

    task automatic run_auto(input string tag, input logic [1:0] dut, input int n_ch, input int dwell,
                            input int n_items, input int stall_at);
        logic [2:0] c;
        phase = tag;
        act   = dut;
        mode  = 1'b1;
        tick();
        for (int i = 0; i < n_items; i++) begin
            c = 3'((i / dwell) % n_ch);
            exp_q.push_back({pat[c], c, 1'b0, ((i % (n_ch * dwell)) == n_ch * dwell - 1)});
        end
        en = 1'b1;
        drain(stall_at);
        mode = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        rst       = 1'b1;
        en        = 1'b0;
        mode      = 1'b0;
        sel_in    = 3'd0;
        sel_load  = 1'b0;
        out_ready = 1'b1;
        act       = 2'd0;
        pat       = 8'b01100101;
`ifdef MUX_CH_MASK_EN
        mask      = 8'hFF;
`endif
        repeat (3) tick();
        phase = "reset";
        chk("reset_a", {1'b0, v_a, d_a, s_a, dn_a, er_a}, 8'h00);
        chk("reset_b", {1'b0, v_b, d_b, s_b, dn_b, er_b}, 8'h00);
        chk("reset_c", {1'b0, v_c, d_c, s_c, dn_c, er_c}, 8'h00);
        rst = 1'b0;
        tick();

        run_manual("manual_sweep", 2'd0, 8, 24'o76543210, 8);
        run_manual("out_of_range", 2'd1, 6, 24'o2765, 4);
        run_auto("auto_dwell2_stall", 2'd0, 8, 2, 34, 24);
        run_auto("auto_n6_wrap", 2'd1, 6, 1, 13, -1);

        // Asynchronous reset in the middle of a running scan
        phase = "async_reset";
        act   = 2'd0;
        mode  = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({pat[3'(i / 2)], 3'(i / 2), 1'b0, 1'b0});
        end
        en = 1'b1;
        g  = 0;
        while (exp_q.size() > 2 && g < 50) begin
            tick();
            mon();
            g++;
        end
        tick();
        chk("pre_reset_valid", {7'b0, cv}, 8'h01);
        #1 rst = 1'b1;
        #1;
        chk("reset_immediate", {1'b0, cv, cd, cs, cdn, cer}, 8'h00);
        exp_q.delete();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({pat[3'(i / 2)], 3'(i / 2), 1'b0, 1'b0});
        end
        drain(-1);
        mode = 1'b0;
        tick();

`ifdef MUX_CH_MASK_EN
        phase = "mask_scan";
        act   = 2'd2;
        mask  = 8'b10010010;
        mode  = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            logic [2:0] c;
            c = (i % 3 == 0) ? 3'd1 : ((i % 3 == 1) ? 3'd4 : 3'd7);
            exp_q.push_back({pat[c], c, 1'b0, (c == 3'd7)});
        end
        en = 1'b1;
        drain(-1);
        phase = "mask_zero";
        mask  = 8'h00;
        en    = 1'b1;
        repeat (10) begin
            tick();
            chk("mask0_valid", {7'b0, cv}, 8'h00);
        end
        en   = 1'b0;
        mode = 1'b0;
        tick();
`else
        run_auto("auto_dwell1", 2'd2, 8, 1, 9, -1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
